// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the functional units.
// Each FU has a one-entry holding buffer with a valid/ready handshake. Every
// cycle the valid buffer whose ROB index is oldest relative to the ROB head
// is broadcast on the CDB. Ties go to the lower FU index.
//
// Ports:
//   in_clk, in_rst_n          clock, asynchronous active-low reset
//   in_fu_*                   per-FU result payloads, FU i in slice i
//   out_fu_ready              per-FU buffer can accept this cycle
//   in_rob_head_index         oldest ROB entry, the reference for age
//   in_flush                  drop all buffered and incoming results
//   out_cdb_*                 registered broadcast; done is a one-cycle pulse
//   out_conflict_count        saturating count of cycles with >=2 buffers valid
module cdb_arbiter #(
    parameter int unsigned NUM_FU       = 2,
    parameter int unsigned GPR_SIZE     = 64,
    parameter int unsigned ROB_IDX_SIZE = 4
) (
    input  logic                           in_clk,
    input  logic                           in_rst_n,
    input  logic [NUM_FU-1:0]              in_fu_done,
    input  logic [NUM_FU*ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
    input  logic [NUM_FU*GPR_SIZE-1:0]     in_fu_value,
    input  logic [NUM_FU-1:0]              in_fu_set_nzcv,
    input  logic [NUM_FU*4-1:0]            in_fu_nzcv,
    input  logic [NUM_FU-1:0]              in_fu_is_mispred,
    output logic [NUM_FU-1:0]              out_fu_ready,
    input  logic [ROB_IDX_SIZE-1:0]        in_rob_head_index,
    input  logic                           in_flush,
    output logic                           out_cdb_done,
    output logic [ROB_IDX_SIZE-1:0]        out_cdb_rob_index,
    output logic [GPR_SIZE-1:0]            out_cdb_value,
    output logic                           out_cdb_set_nzcv,
    output logic [3:0]                     out_cdb_nzcv,
    output logic                           out_cdb_is_mispred,
    output logic [15:0]                    out_conflict_count
);

    localparam int unsigned FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned CNT_W    = 16;

    typedef struct packed {
        logic [ROB_IDX_SIZE-1:0] rob_index;
        logic [GPR_SIZE-1:0]     value;
        logic                    set_nzcv;
        logic [3:0]              nzcv;
        logic                    is_mispred;
    } cdb_payload_t;

    cdb_payload_t            fu_in     [NUM_FU];
    cdb_payload_t            buf_q     [NUM_FU];
    logic [NUM_FU-1:0]       buf_valid_q;
    logic [ROB_IDX_SIZE-1:0] age       [NUM_FU];
    logic [NUM_FU-1:0]       grant;
    logic                    grant_any;
    logic [FU_IDX_W-1:0]     grant_idx;
    logic [ROB_IDX_SIZE-1:0] best_age;
    logic [NUM_FU-1:0]       accept;
    logic                    conflict;

    // Unpack the flat per-FU input buses and compute modular age vs. head.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_in[i].rob_index  = in_fu_dst_rob_index[i*ROB_IDX_SIZE +: ROB_IDX_SIZE];
            fu_in[i].value      = in_fu_value[i*GPR_SIZE +: GPR_SIZE];
            fu_in[i].set_nzcv   = in_fu_set_nzcv[i];
            fu_in[i].nzcv       = in_fu_nzcv[i*4 +: 4];
            fu_in[i].is_mispred = in_fu_is_mispred[i];
            age[i]              = ROB_IDX_SIZE'(buf_q[i].rob_index - in_rob_head_index);
        end
    end

    // Oldest-first select; strict '<' keeps the lowest FU index on ties.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        best_age  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (buf_valid_q[i] && (!grant_any || (age[i] < best_age))) begin
                grant_any = 1'b1;
                grant_idx = FU_IDX_W'(i);
                best_age  = age[i];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Ready: empty or draining this cycle; forced open during flush, closed in reset.
    always_comb begin
        if (!in_rst_n) begin
            out_fu_ready = '0;
        end else if (in_flush) begin
            out_fu_ready = '1;
        end else begin
            out_fu_ready = ~buf_valid_q | grant;
        end
    end

    assign accept = in_fu_done & out_fu_ready;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign conflict = (buf_valid_q & NUM_FU'(buf_valid_q - NUM_FU'(1))) != '0;

    // Holding buffers: flush beats accept beats drain.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            buf_valid_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (in_flush) begin
                    buf_valid_q[i] <= 1'b0;
                end else if (accept[i]) begin
                    buf_valid_q[i] <= 1'b1;
                    buf_q[i]       <= fu_in[i];
                end else if (grant[i]) begin
                    buf_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // CDB broadcast register; payload holds when nothing is granted.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_cdb_done       <= 1'b0;
            out_cdb_rob_index  <= '0;
            out_cdb_value      <= '0;
            out_cdb_set_nzcv   <= 1'b0;
            out_cdb_nzcv       <= '0;
            out_cdb_is_mispred <= 1'b0;
        end else if (in_flush) begin
            out_cdb_done <= 1'b0;
        end else if (grant_any) begin
            out_cdb_done       <= 1'b1;
            out_cdb_rob_index  <= buf_q[grant_idx].rob_index;
            out_cdb_value      <= buf_q[grant_idx].value;
            out_cdb_set_nzcv   <= buf_q[grant_idx].set_nzcv;
            out_cdb_nzcv       <= buf_q[grant_idx].nzcv;
            out_cdb_is_mispred <= buf_q[grant_idx].is_mispred;
        end else begin
            out_cdb_done <= 1'b0;
        end
    end

    // Saturating contention counter; survives flush.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_conflict_count <= '0;
        end else if (!in_flush && conflict && (out_conflict_count != '1)) begin
            out_conflict_count <= out_conflict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_FU=2, 64-bit values, 16-entry ROB).
module tb_cdb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   fu_done;
    logic [7:0]   fu_rob_idx;
    logic [127:0] fu_value;
    logic [1:0]   fu_set_nzcv;
    logic [7:0]   fu_nzcv;
    logic [1:0]   fu_mispred;
    logic [1:0]   fu_ready;
    logic [3:0]   head;
    logic         flush;
    logic         cdb_done;
    logic [3:0]   cdb_rob_idx;
    logic [63:0]  cdb_value;
    logic         cdb_set_nzcv;
    logic [3:0]   cdb_nzcv;
    logic         cdb_mispred;
    logic [15:0]  conflict_count;

    int checks = 0;
    int errors = 0;

    localparam int ALU = 0;
    localparam int LS  = 1;

    cdb_arbiter #(.NUM_FU(2), .GPR_SIZE(64), .ROB_IDX_SIZE(4)) dut (
        .in_clk              (clk),
        .in_rst_n            (rst_n),
        .in_fu_done          (fu_done),
        .in_fu_dst_rob_index (fu_rob_idx),
        .in_fu_value         (fu_value),
        .in_fu_set_nzcv      (fu_set_nzcv),
        .in_fu_nzcv          (fu_nzcv),
        .in_fu_is_mispred    (fu_mispred),
        .out_fu_ready        (fu_ready),
        .in_rob_head_index   (head),
        .in_flush            (flush),
        .out_cdb_done        (cdb_done),
        .out_cdb_rob_index   (cdb_rob_idx),
        .out_cdb_value       (cdb_value),
        .out_cdb_set_nzcv    (cdb_set_nzcv),
        .out_cdb_nzcv        (cdb_nzcv),
        .out_cdb_is_mispred  (cdb_mispred),
        .out_conflict_count  (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fu(input int fu, input logic done, input logic [3:0] idx,
                            input logic [63:0] val, input logic snz, input logic [3:0] nz,
                            input logic mp);
        fu_done[fu]          = done;
        fu_rob_idx[fu*4 +: 4] = idx;
        fu_value[fu*64 +: 64] = val;
        fu_set_nzcv[fu]      = snz;
        fu_nzcv[fu*4 +: 4]    = nz;
        fu_mispred[fu]       = mp;
    endtask

    initial begin
        rst_n       = 1'b0;
        fu_done     = '0;
        fu_rob_idx  = '0;
        fu_value    = '0;
        fu_set_nzcv = '0;
        fu_nzcv     = '0;
        fu_mispred  = '0;
        head        = '0;
        flush       = 1'b0;

        // Reset state
        #2;
        check("rst_ready", 64'(fu_ready), 64'h0);
        check("rst_done", 64'(cdb_done), 64'h0);
        check("rst_count", 64'(conflict_count), 64'h0);
        check("rst_value", cdb_value, 64'h0);
        #10 rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(fu_ready), 64'h3);
        step();

        // Single result, 2-edge latency, one-cycle pulse, payload holds
        head = 4'd0;
        drive_fu(ALU, 1'b1, 4'd3, 64'h1000, 1'b0, 4'h0, 1'b0);
        step();
        drive_fu(ALU, 1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        #1;
        check("single_not_yet", 64'(cdb_done), 64'h0);
        step();
        check("single_done", 64'(cdb_done), 64'h1);
        check("single_idx", 64'(cdb_rob_idx), 64'h3);
        check("single_value", cdb_value, 64'h1000);
        step();
        check("single_pulse_end", 64'(cdb_done), 64'h0);
        check("single_idx_hold", 64'(cdb_rob_idx), 64'h3);

        // Contention: LS (age 1) beats ALU (age 3)
        head = 4'd2;
        drive_fu(ALU, 1'b1, 4'd5, 64'hA5, 1'b0, 4'h0, 1'b0);
        drive_fu(LS,  1'b1, 4'd3, 64'hB3, 1'b1, 4'hA, 1'b1);
        step();
        drive_fu(ALU, 1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        drive_fu(LS,  1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        #1;
        check("cont_ready", 64'(fu_ready), 64'h2);
        step();
        check("cont_first_done", 64'(cdb_done), 64'h1);
        check("cont_first_idx", 64'(cdb_rob_idx), 64'h3);
        check("cont_first_value", cdb_value, 64'hB3);
        check("cont_first_snz", 64'(cdb_set_nzcv), 64'h1);
        check("cont_first_nzcv", 64'(cdb_nzcv), 64'hA);
        check("cont_first_mispred", 64'(cdb_mispred), 64'h1);
        check("cont_count", 64'(conflict_count), 64'h1);
        check("cont_ready2", 64'(fu_ready), 64'h3);
        step();
        check("cont_second_done", 64'(cdb_done), 64'h1);
        check("cont_second_idx", 64'(cdb_rob_idx), 64'h5);
        check("cont_second_value", cdb_value, 64'hA5);
        check("cont_second_mispred", 64'(cdb_mispred), 64'h0);
        check("cont_count_hold", 64'(conflict_count), 64'h1);
        step();
        check("cont_idle", 64'(cdb_done), 64'h0);

        // Wrap-around: head 14, LS idx 15 (age 1) before ALU idx 1 (age 3)
        head = 4'd14;
        drive_fu(ALU, 1'b1, 4'd1, 64'h11, 1'b0, 4'h0, 1'b0);
        drive_fu(LS,  1'b1, 4'd15, 64'hFF, 1'b0, 4'h0, 1'b0);
        step();
        drive_fu(ALU, 1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        drive_fu(LS,  1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        step();
        check("wrap_first_idx", 64'(cdb_rob_idx), 64'hF);
        check("wrap_first_done", 64'(cdb_done), 64'h1);
        step();
        check("wrap_second_idx", 64'(cdb_rob_idx), 64'h1);
        check("wrap_second_done", 64'(cdb_done), 64'h1);
        check("wrap_count", 64'(conflict_count), 64'h2);
        step();

        // Streaming: drain and refill in the same cycle
        head = 4'd4;
        drive_fu(ALU, 1'b1, 4'd4, 64'h44, 1'b0, 4'h0, 1'b0);
        step();
        drive_fu(ALU, 1'b1, 4'd5, 64'h55, 1'b0, 4'h0, 1'b0);
        #1;
        check("stream_ready_a", 64'(fu_ready[ALU]), 64'h1);
        step();
        check("stream_done_4", 64'(cdb_done), 64'h1);
        check("stream_idx_4", 64'(cdb_rob_idx), 64'h4);
        drive_fu(ALU, 1'b1, 4'd6, 64'h66, 1'b0, 4'h0, 1'b0);
        #1;
        check("stream_ready_b", 64'(fu_ready[ALU]), 64'h1);
        step();
        check("stream_done_5", 64'(cdb_done), 64'h1);
        check("stream_idx_5", 64'(cdb_rob_idx), 64'h5);
        check("stream_value_5", cdb_value, 64'h55);
        drive_fu(ALU, 1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        step();
        check("stream_done_6", 64'(cdb_done), 64'h1);
        check("stream_idx_6", 64'(cdb_rob_idx), 64'h6);
        step();
        check("stream_end", 64'(cdb_done), 64'h0);

        // Flush with both buffers full and an incoming result
        head = 4'd0;
        drive_fu(ALU, 1'b1, 4'd2, 64'h22, 1'b0, 4'h0, 1'b0);
        drive_fu(LS,  1'b1, 4'd7, 64'h77, 1'b0, 4'h0, 1'b0);
        step();
        drive_fu(ALU, 1'b1, 4'd9, 64'h99, 1'b0, 4'h0, 1'b0);
        drive_fu(LS,  1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(fu_ready), 64'h3);
        step();
        flush = 1'b0;
        drive_fu(ALU, 1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        #1;
        check("flush_done", 64'(cdb_done), 64'h0);
        check("flush_empty_ready", 64'(fu_ready), 64'h3);
        check("flush_count_kept", 64'(conflict_count), 64'h2);
        step();
        check("flush_no_bcast", 64'(cdb_done), 64'h0);
        step();
        check("flush_no_bcast2", 64'(cdb_done), 64'h0);

        // Asynchronous reset in the middle of a broadcast pulse
        drive_fu(ALU, 1'b1, 4'd5, 64'h5A, 1'b0, 4'h0, 1'b0);
        step();
        drive_fu(ALU, 1'b0, 4'd0, 64'h0, 1'b0, 4'h0, 1'b0);
        step();
        check("pre_rst_done", 64'(cdb_done), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_done", 64'(cdb_done), 64'h0);
        check("async_rst_count", 64'(conflict_count), 64'h0);
        check("async_rst_ready", 64'(fu_ready), 64'h0);
        step();
        check("rst_held_ready", 64'(fu_ready), 64'h0);
        #3 rst_n = 1'b1;
        #1;
        check("rel_ready", 64'(fu_ready), 64'h3);
        check("rel_done", 64'(cdb_done), 64'h0);
        step();
        check("rel_no_pulse", 64'(cdb_done), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
